lcd_pattern_gen: RTL

Frame-drawing sequencer that sits directly upstream of `ili934x_driver`. On a start request it validates and latches a rectangle and waits for `init_done` and an idle driver. It then issues the window-set and memory-write strobes and streams one RGB565 pixel per accepted handshake, in raster order, until the rectangle is filled. It drives the driver's window, stream and pixel ports; its pattern modes are used for bring-up and for solid fills.

---
 rtl/lcd_pattern_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_gen.sv
// Frame-drawing sequencer feeding ili934x_driver: validates and latches a window,
// issues the window/stream strobes, then streams RGB565 pattern pixels in raster order.
module lcd_pattern_gen #(
    parameter int X_RES     = 240,
    parameter int Y_RES     = 320,
    parameter int BAR_SHIFT = 5,
    parameter int CHK_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [15:0] fg_color,
    input  logic [15:0] bg_color,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic        init_done,
    input  logic        drv_busy,
    output logic        win_set_stb,
    output logic [15:0] win_x0,
    output logic [15:0] win_y0,
    output logic [15:0] win_x1,
    output logic [15:0] win_y1,
    output logic        stream_start,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        active,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, WAIT_INIT, WIN, STRM, PIX, DONE} state_t;

    localparam logic [15:0] X_LIM = 16'(X_RES);
    localparam logic [15:0] Y_LIM = 16'(Y_RES);

    state_t      state, state_nxt;
    logic [1:0]  mode_l;
    logic [15:0] fg_l, bg_l;
    logic [15:0] x_cnt, y_cnt, x_nxt, y_nxt;
    logic        win_bad, accept, transfer, last_pix;

    function automatic logic [15:0] pattern(input logic [1:0] m, input logic [15:0] fg,
                                            input logic [15:0] bg, input logic [15:0] xr,
                                            input logic [15:0] yr);
        logic [2:0] bar;
        bar = 3'(xr >> BAR_SHIFT);
        case (m)
            2'd0: pattern = fg;
            2'd1: begin
                case (bar)
                    3'd0: pattern = 16'hFFFF;
                    3'd1: pattern = 16'hFFE0;
                    3'd2: pattern = 16'h07FF;
                    3'd3: pattern = 16'h07E0;
                    3'd4: pattern = 16'hF81F;
                    3'd5: pattern = 16'hF800;
                    3'd6: pattern = 16'h001F;
                    default: pattern = 16'h0000;
                endcase
            end
            2'd2: pattern = (xr[CHK_SHIFT] ^ yr[CHK_SHIFT]) ? bg : fg;
            default: pattern = {xr[4:0], yr[5:0], ~xr[4:0]};
        endcase
    endfunction

    assign win_bad  = (x1 < x0) || (y1 < y0) || (x1 >= X_LIM) || (y1 >= Y_LIM);
    assign accept   = (state == IDLE) && start && !abort && !win_bad;
    assign transfer = (state == PIX) && pix_ready;
    assign last_pix = (x_cnt == win_x1) && (y_cnt == win_y1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_cnt + 16'd1;
        y_nxt     = y_cnt;
        if (x_cnt == win_x1) begin
            x_nxt = win_x0;
            y_nxt = y_cnt + 16'd1;
        end
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (accept) state_nxt = WAIT_INIT;
                WAIT_INIT: if (init_done && !drv_busy) state_nxt = WIN;
                WIN:       state_nxt = STRM;
                STRM:      state_nxt = PIX;
                PIX:       if (transfer && last_pix) state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Strobes and flags are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_set_stb  <= 1'b0;
            stream_start <= 1'b0;
            pix_valid    <= 1'b0;
            active       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            pix_data     <= '0;
            win_x0       <= '0;
            win_y0       <= '0;
            win_x1       <= '0;
            win_y1       <= '0;
            mode_l       <= '0;
            fg_l         <= '0;
            bg_l         <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
        end else begin
            win_set_stb  <= (state_nxt == WIN);
            stream_start <= (state_nxt == STRM);
            pix_valid    <= (state_nxt == PIX);
            active       <= (state_nxt != IDLE);
            done         <= (state_nxt == DONE);
            err          <= (state == IDLE) && start && !abort && win_bad;
            if (abort) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                pix_data <= '0;
            end else if (accept) begin
                win_x0 <= x0;
                win_y0 <= y0;
                win_x1 <= x1;
                win_y1 <= y1;
                mode_l <= mode;
                fg_l   <= fg_color;
                bg_l   <= bg_color;
                x_cnt  <= x0;
                y_cnt  <= y0;
            end else if (state == STRM) begin
                pix_data <= pattern(mode_l, fg_l, bg_l, x_cnt - win_x0, y_cnt - win_y0);
            end else if (transfer) begin
                x_cnt    <= x_nxt;
                y_cnt    <= y_nxt;
                pix_data <= pattern(mode_l, fg_l, bg_l, x_nxt - win_x0, y_nxt - win_y0);
            end
        end
    end

endmodule
